opb_single_master: RTL and testbench

OPB_SINGLE_MASTER -- requirements
Module: opb_single_master

---
 rtl/opb_single_master_if.sv | 62 ++++++
 rtl/opb_single_master.sv | 220 ++++++++++++++++++++++
 tb/tb_opb_single_master.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opb_single_master_if.sv
// Command/response handshake plus OPB master-side bus signals for opb_single_master.
// Bit vectors follow OPB big-endian numbering: bit 0 is the most significant bit.
interface opb_single_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  localparam int unsigned BEW = DW / 8;

  // command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rnw;
  logic [0:AW-1]     cmd_addr;
  logic [0:BEW-1]    cmd_be;
  logic [0:DW-1]     cmd_wdata;

  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:DW-1]     rsp_data;
  logic [1:0]        rsp_status;

  // OPB master outputs
  logic              M_request;
  logic              M_select;
  logic              M_RNW;
  logic [0:AW-1]     M_ABus;
  logic [0:BEW-1]    M_BE;
  logic [0:DW-1]     M_DBus;
  logic              M_seqAddr;
  logic              M_busLock;

  // OPB arbiter / slave inputs
  logic              OPB_MGrant;
  logic [0:DW-1]     OPB_DBus;
  logic              OPB_xferAck;
  logic              OPB_errAck;
  logic              OPB_retry;
  logic              OPB_toutSup;

  // view from the initiator
  modport master (
    input  cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_status,
    input  rsp_ready,
    output M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, M_busLock,
    input  OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup
  );

  // view from the command source, arbiter and slave side
  modport slave (
    output cmd_valid, cmd_rnw, cmd_addr, cmd_be, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_status,
    output rsp_ready,
    input  M_request, M_select, M_RNW, M_ABus, M_BE, M_DBus, M_seqAddr, M_busLock,
    output OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup
  );

endinterface

// File: rtl/opb_single_master.sv
// Single-beat OPB initiator: accepts one command, arbitrates for the bus, runs one
// select phase (re-arbitrating on retry), and returns a status/data response.
// Timeline with immediate grant and ack on the first select cycle:
//   accept cycle -> REQ (grant seen) -> REQ (granted) -> XFER (ack) -> RESP
// so rsp_valid is first high four cycles after the accept cycle.
// Every output is registered and computed from the next state, so M_select is high
// exactly while the FSM sits in XFER and the bus vectors are zero otherwise.
module opb_single_master #(
  parameter int unsigned C_OPB_AWIDTH  = 32,
  parameter int unsigned C_OPB_DWIDTH  = 32,
  parameter int unsigned C_TOUT_CYCLES = 16,
  parameter int unsigned C_MAX_RETRY   = 8
) (
  input logic                 OPB_Clk,
  input logic                 OPB_Rst_n,
  opb_single_master_if.master bus
);

  localparam int unsigned AW  = C_OPB_AWIDTH;
  localparam int unsigned DW  = C_OPB_DWIDTH;
  localparam int unsigned BEW = C_OPB_DWIDTH / 8;
  localparam int unsigned TW  = 8;
  localparam int unsigned RW  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_ERRACK    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT   = 2'd2;
  localparam logic [1:0] ST_RETRY_EXH = 2'd3;

  // FSM and command registers
  logic [1:0]     state, state_d;
  logic           granted, granted_d;
  logic           rnw_q, rnw_d;
  logic [0:AW-1]  addr_q, addr_d;
  logic [0:BEW-1] be_q, be_d;
  logic [0:DW-1]  wdata_q, wdata_d;
  logic [RW-1:0]  retry_cnt, retry_d;
  logic [TW-1:0]  tout_cnt, tout_d;
  logic [TW-1:0]  tout_inc;

  // registered outputs
  logic           cmd_ready, cmd_ready_d;
  logic           rsp_valid, rsp_valid_d;
  logic [0:DW-1]  rsp_data, rsp_data_d;
  logic [1:0]     rsp_status, rsp_status_d;
  logic           m_request, m_request_d;
  logic           m_select, m_select_d;
  logic           m_rnw, m_rnw_d;
  logic [0:AW-1]  m_abus, m_abus_d;
  logic [0:BEW-1] m_be, m_be_d;
  logic [0:DW-1]  m_dbus, m_dbus_d;

  assign tout_inc = tout_cnt + TW'(1);

  // next-state, counter and next-output computation
  always_comb begin
    state_d      = state;
    granted_d    = granted;
    rnw_d        = rnw_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    retry_d      = retry_cnt;
    tout_d       = tout_cnt;
    rsp_data_d   = rsp_data;
    rsp_status_d = rsp_status;

    case (state)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          rnw_d        = bus.cmd_rnw;
          addr_d       = bus.cmd_addr;
          be_d         = bus.cmd_be;
          wdata_d      = bus.cmd_wdata;
          retry_d      = '0;
          tout_d       = '0;
          granted_d    = 1'b0;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
          state_d      = S_REQ;
        end
      end

      S_REQ: begin
        // grant is noted on one edge; select is driven from the following cycle
        if (granted) begin
          granted_d = 1'b0;
          tout_d    = '0;
          state_d   = S_XFER;
        end else if (bus.OPB_MGrant) begin
          granted_d = 1'b1;
        end
      end

      S_XFER: begin
        if (bus.OPB_errAck) begin
          rsp_status_d = ST_ERRACK;
          rsp_data_d   = '0;
          state_d      = S_RESP;
        end else if (bus.OPB_xferAck) begin
          rsp_status_d = ST_OK;
          rsp_data_d   = rnw_q ? bus.OPB_DBus : '0;
          state_d      = S_RESP;
        end else if (bus.OPB_retry) begin
          // C_MAX_RETRY re-arbitrations are allowed; one more retry aborts
          retry_d = retry_cnt + RW'(1);
          if (retry_cnt < RW'(C_MAX_RETRY)) begin
            state_d = S_REQ;
          end else begin
            rsp_status_d = ST_RETRY_EXH;
            rsp_data_d   = '0;
            state_d      = S_RESP;
          end
        end else if (!bus.OPB_toutSup) begin
          tout_d = tout_inc;
          if (tout_inc == TW'(C_TOUT_CYCLES)) begin
            rsp_status_d = ST_TIMEOUT;
            rsp_data_d   = '0;
            state_d      = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (rsp_valid && bus.rsp_ready) begin
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    m_request_d = (state_d == S_REQ);
    m_select_d  = (state_d == S_XFER);
    m_rnw_d     = m_select_d ? rnw_d : 1'b0;
    m_abus_d    = m_select_d ? addr_d : '0;
    m_be_d      = m_select_d ? be_d : '0;
    m_dbus_d    = (m_select_d && !rnw_d) ? wdata_d : '0;
  end

  // state, command, counter and output registers
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state      <= S_IDLE;
      granted    <= 1'b0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      retry_cnt  <= '0;
      tout_cnt   <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= ST_OK;
      m_request  <= 1'b0;
      m_select   <= 1'b0;
      m_rnw      <= 1'b0;
      m_abus     <= '0;
      m_be       <= '0;
      m_dbus     <= '0;
    end else begin
      state      <= state_d;
      granted    <= granted_d;
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      retry_cnt  <= retry_d;
      tout_cnt   <= tout_d;
      cmd_ready  <= cmd_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_status <= rsp_status_d;
      m_request  <= m_request_d;
      m_select   <= m_select_d;
      m_rnw      <= m_rnw_d;
      m_abus     <= m_abus_d;
      m_be       <= m_be_d;
      m_dbus     <= m_dbus_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = rsp_data;
  assign bus.rsp_status = rsp_status;
  assign bus.M_request  = m_request;
  assign bus.M_select   = m_select;
  assign bus.M_RNW      = m_rnw;
  assign bus.M_ABus     = m_abus;
  assign bus.M_BE       = m_be;
  assign bus.M_DBus     = m_dbus;
  assign bus.M_seqAddr  = 1'b0;
  assign bus.M_busLock  = 1'b0;

  // request and select are never high together
  a_req_sel_excl: assert property (@(posedge OPB_Clk) disable iff (!OPB_Rst_n)
    !(m_request && m_select));

  // OR-bus outputs stay zero while not selected
  a_bus_zero: assert property (@(posedge OPB_Clk) disable iff (!OPB_Rst_n)
    !m_select |-> (m_abus == '0 && m_be == '0 && !m_rnw && m_dbus == '0));

  // a pending response holds steady until consumed
  a_rsp_stable: assert property (@(posedge OPB_Clk) disable iff (!OPB_Rst_n)
    (rsp_valid && !bus.rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_status)));

endmodule

// File: tb/tb_opb_single_master.sv
// Randomized bench for opb_single_master: the bench plays command source, arbiter and
// slave from a per-attempt script, and a transaction-level model predicts the outcome.
module tb_opb_single_master;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned TOUT = 16;
  localparam int unsigned MAXR = 8;

  localparam int K_OK    = 0;
  localparam int K_ERR   = 1;
  localparam int K_BOTH  = 2;
  localparam int K_RETRY = 3;
  localparam int K_NONE  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // slave script: behaviour per select attempt
  int kind [10];
  int dly  [10];
  int sup  [10];

  opb_single_master_if #(.AW(AW), .DW(DW)) bus ();

  opb_single_master #(
    .C_OPB_AWIDTH (AW),
    .C_OPB_DWIDTH (DW),
    .C_TOUT_CYCLES(TOUT),
    .C_MAX_RETRY  (MAXR)
  ) dut (
    .OPB_Clk  (clk),
    .OPB_Rst_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_opb();
    bus.OPB_MGrant  = 1'b0;
    bus.OPB_xferAck = 1'b0;
    bus.OPB_errAck  = 1'b0;
    bus.OPB_retry   = 1'b0;
    bus.OPB_toutSup = 1'b0;
    bus.OPB_DBus    = '0;
  endtask

  // one full transaction; exp_lat > 0 also checks accept-to-rsp_valid cycles
  task automatic run_txn(input logic rnw, input logic [0:AW-1] addr, input logic [0:3] be,
                         input logic [0:DW-1] wdata, input logic [0:DW-1] rdata,
                         input int gd, input int exp_lat);
    int exp_att, exp_sel, exp_status;
    logic [0:DW-1] exp_data;
    int att, ai, sel_total, sel_idx, req_run, req_edges, lat, w;
    logic prev_req, prev_sel, done;

    // transaction-level prediction from the slave script
    exp_att = 0; exp_sel = 0; exp_status = 0; exp_data = '0;
    for (int i = 0; i < 10; i++) begin
      exp_att = i + 1;
      if (kind[i] == K_NONE) begin
        exp_sel += sup[i] + int'(TOUT);
        exp_status = 2;
        break;
      end
      exp_sel += dly[i] + 1;
      if (kind[i] == K_OK) begin
        exp_status = 0;
        exp_data = rnw ? rdata : '0;
        break;
      end
      if (kind[i] == K_ERR || kind[i] == K_BOTH) begin
        exp_status = 1;
        break;
      end
      if (i >= int'(MAXR)) begin
        exp_status = 3;
        break;
      end
    end

    @(negedge clk);
    check("ready_idle", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_rnw   = rnw;
    bus.cmd_addr  = addr;
    bus.cmd_be    = be;
    bus.cmd_wdata = wdata;

    att = 0; sel_total = 0; sel_idx = 0; req_run = 0; req_edges = 0;
    prev_req = 1'b0; prev_sel = 1'b0; done = 1'b0; lat = 0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_rnw   = 1'($urandom);
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_be    = 4'($urandom);
        bus.cmd_wdata = DW'($urandom);
        check("ready_busy", 64'(bus.cmd_ready), 64'(0));
      end
      clear_opb();
      bus.OPB_DBus = DW'($urandom);
      if (bus.M_request && !prev_req) req_edges++;
      req_run = bus.M_request ? req_run + 1 : 0;
      if (bus.M_request && req_run > gd) bus.OPB_MGrant = 1'b1;
      if (bus.M_select) begin
        if (!prev_sel) begin
          att++;
          sel_idx = 0;
        end else begin
          sel_idx++;
        end
        sel_total++;
        ai = (att > 10) ? 9 : att - 1;
        check("m_abus", 64'(bus.M_ABus), 64'(addr));
        check("m_be", 64'(bus.M_BE), 64'(be));
        check("m_rnw", 64'(bus.M_RNW), 64'(rnw));
        check("m_dbus", 64'(bus.M_DBus), rnw ? 64'(0) : 64'(wdata));
        if (kind[ai] == K_NONE) begin
          bus.OPB_toutSup = (sel_idx < sup[ai]);
        end else if (sel_idx == dly[ai]) begin
          bus.OPB_DBus = rdata;
          case (kind[ai])
            K_OK:    bus.OPB_xferAck = 1'b1;
            K_ERR:   bus.OPB_errAck  = 1'b1;
            K_BOTH:  begin bus.OPB_errAck = 1'b1; bus.OPB_xferAck = 1'b1; end
            default: bus.OPB_retry   = 1'b1;
          endcase
        end
      end else begin
        check("bus_zero", 64'({bus.M_ABus, bus.M_BE, bus.M_RNW, bus.M_DBus}), 64'(0));
        // stray slave responses outside select must be ignored
        if ($urandom_range(0, 3) == 0) begin
          bus.OPB_xferAck = 1'b1;
          bus.OPB_errAck  = 1'($urandom);
          bus.OPB_retry   = 1'($urandom);
        end
      end
      if (bus.rsp_valid) begin
        lat = cyc;
        done = 1'b1;
      end
      prev_req = bus.M_request;
      prev_sel = bus.M_select;
    end
    clear_opb();

    check("rsp_seen", 64'(done), 64'(1));
    if (done) begin
      check("rsp_status", 64'(bus.rsp_status), 64'(exp_status));
      check("rsp_data", 64'(bus.rsp_data), 64'(exp_data));
      check("attempts", 64'(att), 64'(exp_att));
      check("requests", 64'(req_edges), 64'(exp_att));
      check("sel_cycles", 64'(sel_total), 64'(exp_sel));
      if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
      w = int'($urandom_range(0, 3));
      for (int j = 0; j < w; j++) begin
        @(negedge clk);
        check("hold_valid", 64'(bus.rsp_valid), 64'(1));
        check("hold_status", 64'(bus.rsp_status), 64'(exp_status));
        check("hold_data", 64'(bus.rsp_data), 64'(exp_data));
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("post_valid", 64'(bus.rsp_valid), 64'(0));
      check("post_ready", 64'(bus.cmd_ready), 64'(1));
    end
  endtask

  task automatic script_fill(input int k, input int d, input int s);
    for (int i = 0; i < 10; i++) begin
      kind[i] = k;
      dly[i]  = d;
      sup[i]  = s;
    end
  endtask

  initial begin
    int r, sel_seen;
    logic saw;
    bus.cmd_valid = 1'b0; bus.cmd_rnw = 1'b0; bus.cmd_addr = '0;
    bus.cmd_be = '0; bus.cmd_wdata = '0; bus.rsp_ready = 1'b0;
    clear_opb();

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check("rst_outs", 64'({bus.rsp_valid, bus.M_request, bus.M_select, bus.M_seqAddr, bus.M_busLock}), 64'(0));
    check("rst_rsp", 64'({bus.rsp_data, bus.rsp_status}), 64'(0));
    check("rst_bus", 64'({bus.M_ABus, bus.M_BE, bus.M_RNW, bus.M_DBus}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 64'(bus.cmd_ready), 64'(1));

    // minimum latency write, then the directed read and write cases
    script_fill(K_OK, 0, 0);
    run_txn(1'b0, 32'h0000_0100, 4'hF, 32'hA5A5_5A5A, 32'h1111_2222, 0, 4);
    script_fill(K_OK, 1, 0);
    run_txn(1'b1, 32'h0118_8400, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 5);
    script_fill(K_OK, 0, 0);
    run_txn(1'b0, 32'h0000_0040, 4'hF, 32'h1234_5678, 32'hCAFE_F00D, 1, 5);

    // every attempt retried: MAXR re-requests then abort
    script_fill(K_RETRY, 0, 0);
    run_txn(1'b1, 32'h0000_2000, 4'h3, 32'h0, 32'h5555_AAAA, 0, 0);

    // toutSup held 20 select cycles, then TOUT more before timeout
    script_fill(K_NONE, 0, 20);
    run_txn(1'b1, 32'h0000_3000, 4'hC, 32'h0, 32'h7777_8888, 0, 0);

    // errAck beats xferAck
    script_fill(K_BOTH, 0, 0);
    run_txn(1'b1, 32'h0000_4000, 4'hF, 32'h0, 32'h9999_0000, 0, 0);

    // randomized scripts
    for (int t = 0; t < 40; t++) begin
      r = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
      for (int i = 0; i < 10; i++) begin
        kind[i] = (i < r) ? K_RETRY : int'($urandom_range(0, 4));
        dly[i]  = int'($urandom_range(0, 3));
        sup[i]  = int'($urandom_range(0, 5));
      end
      run_txn(1'($urandom), AW'($urandom), 4'($urandom), DW'($urandom), DW'($urandom),
              int'($urandom_range(0, 2)), 0);
    end

    // reset in the middle of a select phase
    script_fill(K_NONE, 0, 100);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_rnw = 1'b1; bus.cmd_addr = 32'h0000_5000; bus.cmd_be = 4'hF;
    saw = 1'b0;
    sel_seen = 0;
    for (int c = 0; c < 20 && !saw; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.OPB_MGrant = bus.M_request;
      bus.OPB_toutSup = 1'b1;
      if (bus.M_select) sel_seen++;
      if (sel_seen == 3) saw = 1'b1;
    end
    check("sel_before_rst", 64'(saw), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 64'(bus.M_select), 64'(0));
    check("mid_rst_req", 64'(bus.M_request), 64'(0));
    check("mid_rst_ready", 64'(bus.cmd_ready), 64'(0));
    check("mid_rst_bus", 64'({bus.M_ABus, bus.M_BE, bus.M_RNW, bus.M_DBus}), 64'(0));
    clear_opb();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst2", 64'(bus.cmd_ready), 64'(1));
    script_fill(K_OK, 0, 0);
    run_txn(1'b1, 32'h0000_6000, 4'hF, 32'h0, 32'h0BAD_CAFE, 0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
